// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for X^E mod M driving one Montgomery core.
// Optional EXP_SKIP_LZ_EN starts the bit scan at the highest set bit of E (not constant-time).
module modexp_ctrl #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [N-1:0]       in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_r,
  input  logic [N-1:0]       in_r2,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mont_start,
  output logic [N-1:0]       mont_a,
  output logic [N-1:0]       mont_b,
  output logic [N-1:0]       mont_m,
  input  logic [N-1:0]       mont_result,
  input  logic               mont_done
);
  localparam int IW = $clog2(E_WIDTH);
  typedef enum logic [3:0] {IDLE, TOMONT, W_TM, SQ, W_SQ, MUL, W_MUL, FROMMONT, W_FM, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] x_reg, r_reg, r2_reg, xt, acc, op_a, op_b;
  logic [E_WIDTH-1:0] e_reg;
  logic [IW-1:0] idx, start_idx;
  logic armed, got, last, issue, e_zero, bit_set;
`ifdef EXP_SKIP_LZ_EN
  always_comb begin
    start_idx = '0;
    for (int k = 0; k < E_WIDTH; k++) start_idx = e_reg[k] ? IW'(k) : start_idx;
  end
  assign e_zero = ~|e_reg;
`else
  assign start_idx = IW'(E_WIDTH - 1);
  assign e_zero    = 1'b0;
`endif
  // armed is low in the mont_start cycle, so a done level left over from the previous call is ignored
  assign got     = armed && mont_done;
  assign last    = idx == '0;
  assign bit_set = e_reg[idx];
  assign issue   = state == TOMONT || state == SQ || state == MUL || state == FROMMONT;
  assign op_a    = state == TOMONT ? x_reg : acc;
  assign op_b    = state == TOMONT ? r2_reg : state == MUL ? xt : state == FROMMONT ? N'(1) : acc;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? TOMONT : IDLE;
      TOMONT:   state_n = W_TM;
      W_TM:     state_n = !got ? W_TM : e_zero ? FROMMONT : SQ;
      SQ:       state_n = W_SQ;
      W_SQ:     state_n = !got ? W_SQ : bit_set ? MUL : last ? FROMMONT : SQ;
      MUL:      state_n = W_MUL;
      W_MUL:    state_n = !got ? W_MUL : last ? FROMMONT : SQ;
      FROMMONT: state_n = W_FM;
      W_FM:     state_n = got ? DONE : W_FM;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      armed      <= 1'b0;
      x_reg      <= '0;
      r_reg      <= '0;
      r2_reg     <= '0;
      e_reg      <= '0;
      xt         <= '0;
      acc        <= '0;
      idx        <= '0;
    end else begin
      state      <= state_n;
      mont_start <= issue;
      armed      <= !issue;
      done       <= state == DONE;
      if (issue) begin
        mont_a <= op_a;
        mont_b <= op_b;
      end
      if (state == IDLE && start) begin
        x_reg  <= in_x;
        e_reg  <= in_e;
        r_reg  <= in_r;
        r2_reg <= in_r2;
        mont_m <= in_m;
        busy   <= 1'b1;
      end
      if (state == TOMONT) begin
        acc <= r_reg;
        idx <= start_idx;
      end
      if (got && state == W_TM) xt <= mont_result;
      if (got && (state == W_SQ || state == W_MUL || state == W_FM)) acc <= mont_result;
      if (state_n == SQ && state != W_TM) idx <= idx - IW'(1);
      if (state == DONE) begin
        result <= acc;
        busy   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: randomized check of modexp_ctrl against plain modular exponentiation,
// using a behavioural Montgomery core with random latency and an optionally held done level.
module tb_modexp_ctrl;
  localparam int N  = 16;
  localparam int EW = 16;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [N-1:0] in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EW-1:0] in_e = '0;
  logic [N-1:0] result, mont_a, mont_b, mont_m;
  logic [N-1:0] mont_result = '0;
  logic done, busy, mont_start;
  logic mont_done = 1'b0;
  int checks = 0, fails = 0, n_starts = 0, base = 0;
  logic [N-1:0] exp_result = '0, exp_m = '0, held = '0;
  logic [EW-1:0] cur_e = '0;
  bit hold_mode = 0, live = 0, prev_ms = 0, rst_d = 0, pending = 0;
  int cnt = 0, hold_left = 0;
  logic [N-1:0] op_a = '0, op_b = '0, op_m = '0;

  modexp_ctrl #(.N(N), .E_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_m(in_m), .in_e(in_e),
    .in_r(in_r), .in_r2(in_r2), .result(result), .done(done), .busy(busy),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic longint modpow(input longint x, input longint e, input longint m);
    longint r, b;
    r = 1 % m;
    b = x % m;
    while (e > 0) begin
      if ((e & 1) != 0) r = r * b % m;
      b = b * b % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] mont_mul(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    longint t;
    t = longint'(a) * longint'(b);
    for (int k = 0; k < N; k++) begin
      if (t % 2 == 1) t = t + longint'(m);
      t = t / 2;
    end
    if (t >= longint'(m)) t = t - longint'(m);
    return N'(t);
  endfunction

  function automatic int exp_pulses(input logic [EW-1:0] e);
    int pc, top;
    pc = 0;
    top = -1;
    for (int k = 0; k < EW; k++) if (e[k]) begin pc++; top = k; end
`ifdef EXP_SKIP_LZ_EN
    return top < 0 ? 2 : top + 1 + pc + 2;
`else
    return EW + pc + 2;
`endif
  endfunction

  // Montgomery core: result after 1..4 cycles, done pulsed or held 5 cycles (dropped by a new start)
  always @(posedge clk) begin
    if (!resetn) pending = 0;
    else if (mont_start) begin
      op_a = mont_a;
      op_b = mont_b;
      op_m = mont_m;
      cnt = $urandom_range(1, 4);
      pending = 1;
      mont_done <= 1'b0;
    end else if (pending) begin
      cnt--;
      if (cnt == 0) begin
        pending = 0;
        mont_result <= mont_mul(op_a, op_b, op_m);
        mont_done <= 1'b1;
        hold_left = hold_mode ? 5 : 1;
      end
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) mont_done <= 1'b0;
    end
  end

  always @(posedge clk) rst_d <= !resetn;

  always @(negedge clk) begin
    if (rst_d) begin
      live = 1;
      held = '0;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_mont_start", longint'(mont_start), 0);
      chk("rst_result", longint'(result), 0);
      chk("rst_mont_a", longint'(mont_a), 0);
      chk("rst_mont_b", longint'(mont_b), 0);
      chk("rst_mont_m", longint'(mont_m), 0);
    end else if (live) begin
      if (mont_start) begin
        n_starts++;
        chk("mont_start_width", longint'(prev_ms), 0);
      end
      if (done) begin
        chk("result", longint'(result), longint'(exp_result));
        chk("busy_at_done", longint'(busy), 0);
        held = exp_result;
      end else chk("result_held", longint'(result), longint'(held));
      if (busy) chk("mont_m", longint'(mont_m), longint'(exp_m));
      if (busy && pending && !mont_start) begin
        chk("mont_a_stable", longint'(mont_a), longint'(op_a));
        chk("mont_b_stable", longint'(mont_b), longint'(op_b));
      end
    end
    prev_ms = mont_start;
  end

  task automatic launch(input logic [N-1:0] x, input logic [EW-1:0] e, input logic [N-1:0] m, input bit hold);
    logic [N-1:0] r, r2;
    r = N'((longint'(1) << N) % longint'(m));
    r2 = N'(longint'(r) * longint'(r) % longint'(m));
    in_x = x;
    in_e = e;
    in_m = m;
    in_r = r;
    in_r2 = r2;
    hold_mode = hold;
    exp_result = N'(modpow(longint'(x), longint'(e), longint'(m)));
    exp_m = m;
    cur_e = e;
    base = n_starts;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_run(input int extra_at, input longint want);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      start = extra_at > 0 && cyc == extra_at;
      if (start) begin
        in_x = 16'd3;
        in_e = 16'hFFFF;
        in_m = 16'd1001;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    chk("done_in_time", longint'(cyc < 5000), 1);
    chk("pulse_count", longint'(n_starts - base), longint'(exp_pulses(cur_e)));
    chk("busy_after_done", longint'(busy), 0);
    if (want >= 0) chk("result_literal", longint'(result), want);
    @(posedge clk);
    #1 chk("done_single", longint'(done), 0);
  endtask

  initial begin
    logic [N-1:0] m, x;
    logic [EW-1:0] e;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk("pin_modpow_445", modpow(4, 13, 497), 445);
    chk("pin_modpow_23", modpow(2, 10, 1001), 23);
    chk("pin_modpow_e0", modpow(7, 0, 497), 1);
    chk("pin_mont_one", longint'(mont_mul(N'(65536 % 497), N'(1), N'(497))), 1);
    launch(16'd4, 16'd13, 16'd497, 1'b0);
    finish_run(0, 445);
    launch(16'd7, 16'd0, 16'd497, 1'b0);
    finish_run(0, 1);
    launch(16'd4, 16'd13, 16'd497, 1'b1);
    finish_run(0, 445);
    launch(16'd4, 16'd13, 16'd497, 1'b0);
    finish_run(10, 445);
    launch(16'd4, 16'd13, 16'd497, 1'b1);
    for (int c = 0; c < 3000 && n_starts - base < 6; c++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_reached", longint'(n_starts - base >= 6), 1);
    resetn = 1'b0;
    @(posedge clk);
    #1 chk("abort_busy", longint'(busy), 0);
    chk("abort_mont_start", longint'(mont_start), 0);
    chk("abort_result", longint'(result), 0);
    resetn = 1'b1;
    launch(16'd2, 16'd10, 16'd1001, 1'b0);
    finish_run(0, 23);
    for (int k = 0; k < 12; k++) begin
      m = N'($urandom_range(3, 65535)) | N'(1);
      x = N'($urandom_range(0, 32'(m) - 1));
      e = EW'($urandom) >> $urandom_range(0, 15);
      launch(x, e, m, 1'($urandom_range(0, 1)));
      finish_run(0, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
